// File: rtl/load_channel_arbiter_pkg.sv
// Shared types and constants for the memory load-channel arbiter.
package load_channel_arbiter_pkg;

    localparam int NUM_REQUESTERS = 2;
    localparam int REQ_ID_W       = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        DRAIN = 2'd2
    } arbiter_state_t;

    typedef logic [REQ_ID_W-1:0] requester_id_t;

    localparam requester_id_t ICACHE_PORT = REQ_ID_W'(0);
    localparam requester_id_t DCACHE_PORT = REQ_ID_W'(1);

endpackage

// File: rtl/load_channel_arbiter_if.sv
// Requester-side and memory-side load channel signals of the arbiter.
interface load_channel_arbiter_if #(
    parameter int REQUESTERS = 2
);
    logic [REQUESTERS-1:0]       req_request_i;
    logic [REQUESTERS-1:0][31:0] req_address_i;
    logic [REQUESTERS-1:0]       req_lock_i;
    logic [REQUESTERS-1:0]       req_invalidate_i;
    logic [REQUESTERS-1:0]       req_grant_o;
    logic [REQUESTERS-1:0]       req_valid_o;
    logic [31:0]                 req_data_o;
    logic                        mem_request_o;
    logic [31:0]                 mem_address_o;
    logic                        mem_invalidate_o;
    logic [31:0]                 mem_data_i;
    logic                        mem_valid_i;

    modport slave (
        input  req_request_i, req_address_i, req_lock_i, req_invalidate_i,
        input  mem_data_i, mem_valid_i,
        output req_grant_o, req_valid_o, req_data_o,
        output mem_request_o, mem_address_o, mem_invalidate_o
    );

    modport master (
        output req_request_i, req_address_i, req_lock_i, req_invalidate_i,
        output mem_data_i, mem_valid_i,
        input  req_grant_o, req_valid_o, req_data_o,
        input  mem_request_o, mem_address_o, mem_invalidate_o
    );
endinterface

// File: rtl/load_channel_arbiter_picker.sv
// Round-robin pick: first set request bit at or after the pointer, wrapping.
// Purely combinational; one-hot grant plus winner index.
module load_channel_arbiter_picker #(
    parameter int REQUESTERS = 2,
    parameter int ID_W       = 1
) (
    input  logic [REQUESTERS-1:0] i_req,
    input  logic [ID_W-1:0]       i_ptr,
    output logic [REQUESTERS-1:0] o_grant,
    output logic [ID_W-1:0]       o_winner,
    output logic                  o_valid
);
    logic [ID_W-1:0] w_sel;

    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        o_valid  = 1'b0;
        w_sel    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_sel = ID_W'((int'(i_ptr) + i) % REQUESTERS);
            if (!o_valid && i_req[w_sel]) begin
                o_valid        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_winner       = w_sel;
            end
        end
    end
endmodule

// File: rtl/load_channel_arbiter.sv
// Shares the memory load channel between cache controllers: round-robin ownership
// held across a burst, in-order response routing and outstanding-load tracking.
module load_channel_arbiter
    import load_channel_arbiter_pkg::*;
#(
    parameter int REQUESTERS      = NUM_REQUESTERS,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    load_channel_arbiter_if.slave bus,
    output logic                  protocol_error_o
);
    localparam int ID_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(REQUESTERS - 1);

    arbiter_state_t   r_state, w_state_nxt;
    logic [ID_W-1:0]  r_owner, w_owner_nxt;
    logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_outstanding, w_outstanding_nxt;
    logic             r_perr;

    logic [REQUESTERS-1:0] w_eligible;
    logic [REQUESTERS-1:0] w_grant;
    logic [ID_W-1:0]       w_winner;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_inval;
    logic                  w_resp;
    logic                  w_orphan;

    // Invalidate counts only from the current owner while it holds the channel.
    assign w_inval  = (r_state != IDLE) && bus.req_invalidate_i[r_owner];
    assign w_resp   = bus.mem_valid_i && (r_outstanding != '0);
    assign w_orphan = bus.mem_valid_i && (r_outstanding == '0);

    always_comb begin
        w_eligible = '0;
        case (r_state)
            IDLE:    w_eligible = bus.req_request_i;
            OWNED: begin
                if (!w_inval && (r_outstanding < MAX_CNT))
                    w_eligible[r_owner] = bus.req_request_i[r_owner];
            end
            default: w_eligible = '0;
        endcase
    end

    load_channel_arbiter_picker #(
        .REQUESTERS (REQUESTERS),
        .ID_W       (ID_W)
    ) u_picker (
        .i_req    (w_eligible),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_valid  (w_any)
    );

    assign w_accept              = |(w_grant & bus.req_request_i);
    assign bus.req_grant_o       = w_grant;
    assign bus.mem_request_o     = w_accept;
    assign bus.mem_address_o     = w_any ? bus.req_address_i[w_winner] : 32'h0;
    assign bus.mem_invalidate_o  = w_inval;
    assign bus.req_data_o        = bus.mem_data_i;
    assign protocol_error_o      = r_perr;

    always_comb begin
        bus.req_valid_o = '0;
        if (w_resp && !w_inval)
            bus.req_valid_o[r_owner] = 1'b1;
    end

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_inval)
            w_outstanding_nxt = '0;
        else if (w_accept && !w_resp)
            w_outstanding_nxt = r_outstanding + CNT_W'(1);
        else if (!w_accept && w_resp)
            w_outstanding_nxt = r_outstanding - CNT_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_owner_nxt = w_winner;
                    if (bus.req_lock_i[w_winner] || (w_outstanding_nxt != '0))
                        w_state_nxt = OWNED;
                end
            end
            OWNED: begin
                if (w_inval)
                    w_state_nxt = IDLE;
                else if (!bus.req_lock_i[r_owner])
                    w_state_nxt = (w_outstanding_nxt == '0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (w_inval || (w_outstanding_nxt == '0))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Releasing the channel hands priority to the port after the old owner.
        if ((r_state != IDLE) && (w_state_nxt == IDLE))
            w_ptr_nxt = (r_owner == LAST_ID) ? '0 : r_owner + ID_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_ptr         <= '0;
            r_outstanding <= '0;
            r_perr        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_ptr         <= w_ptr_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_perr        <= r_perr | w_orphan;
        end
    end
endmodule

// File: tb/tb_load_channel_arbiter.sv
// Directed bench for load_channel_arbiter: bursts, contention, stall, invalidate, errors.
module tb_load_channel_arbiter;
    import load_channel_arbiter_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic perr;
    int   n_cmp = 0;
    int   n_err = 0;

    load_channel_arbiter_if #(.REQUESTERS(2)) bus ();

    load_channel_arbiter #(
        .REQUESTERS      (2),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .bus              (bus),
        .protocol_error_o (perr)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_request_i    = '0;
        bus.req_address_i    = '0;
        bus.req_lock_i       = '0;
        bus.req_invalidate_i = '0;
        bus.mem_data_i       = '0;
        bus.mem_valid_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        clear_inputs();
        #3;
        n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, IDLE); end
        n_cmp++; if (dut.r_ptr !== 1'b0) begin n_err++; $display("FAIL reset_ptr: got %0d want 0", dut.r_ptr); end
        n_cmp++; if (dut.r_outstanding !== 4'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", dut.r_outstanding); end
        n_cmp++; if (dut.r_owner !== 1'b0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", dut.r_owner); end
        n_cmp++; if (bus.req_grant_o !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", bus.req_grant_o); end
        n_cmp++; if (bus.req_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b want 00", bus.req_valid_o); end
        n_cmp++; if (bus.mem_request_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_request: got %b want 0", bus.mem_request_o); end
        n_cmp++; if (bus.mem_address_o !== 32'h0) begin n_err++; $display("FAIL reset_mem_address: got %h want 0", bus.mem_address_o); end
        n_cmp++; if (bus.mem_invalidate_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_invalidate: got %b want 0", bus.mem_invalidate_o); end
        n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", perr); end
        repeat (2) cyc();
        rst_n_i = 1'b1;
        cyc();
    endtask

    task automatic test_burst();
        logic [31:0] exp_addr;
        for (int k = 0; k < 8; k++) begin
            exp_addr = 32'h1000 + 32'(4 * k);
            bus.req_request_i[ICACHE_PORT] = 1'b1;
            bus.req_lock_i[ICACHE_PORT]    = 1'b1;
            bus.req_address_i[ICACHE_PORT] = exp_addr;
            #1;
            n_cmp++; if (bus.req_grant_o !== 2'b01) begin n_err++; $display("FAIL burst_grant[%0d]: got %b want 01", k, bus.req_grant_o); end
            n_cmp++; if (bus.mem_request_o !== 1'b1) begin n_err++; $display("FAIL burst_mem_request[%0d]: got %b want 1", k, bus.mem_request_o); end
            n_cmp++; if (bus.mem_address_o !== exp_addr) begin n_err++; $display("FAIL burst_addr[%0d]: got %h want %h", k, bus.mem_address_o, exp_addr); end
            cyc();
        end
        bus.req_request_i = '0;
        bus.req_lock_i    = '0;
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b00) begin n_err++; $display("FAIL burst_release_grant: got %b want 00", bus.req_grant_o); end
        cyc();
        n_cmp++; if (dut.r_state !== DRAIN) begin n_err++; $display("FAIL burst_drain_state: got %0d want %0d", dut.r_state, DRAIN); end
        n_cmp++; if (dut.r_outstanding !== 4'd8) begin n_err++; $display("FAIL burst_outstanding: got %0d want 8", dut.r_outstanding); end
        for (int k = 0; k < 8; k++) begin
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i  = 32'hD000_0000 + 32'(k);
            #1;
            n_cmp++; if (bus.req_valid_o !== 2'b01) begin n_err++; $display("FAIL burst_resp_valid[%0d]: got %b want 01", k, bus.req_valid_o); end
            n_cmp++; if (bus.req_data_o !== 32'hD000_0000 + 32'(k)) begin n_err++; $display("FAIL burst_resp_data[%0d]: got %h want %h", k, bus.req_data_o, 32'hD000_0000 + 32'(k)); end
            cyc();
        end
        bus.mem_valid_i = 1'b0;
        n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL burst_end_state: got %0d want %0d", dut.r_state, IDLE); end
        n_cmp++; if (dut.r_ptr !== 1'b1) begin n_err++; $display("FAIL burst_end_ptr: got %0d want 1", dut.r_ptr); end
        n_cmp++; if (dut.r_outstanding !== 4'd0) begin n_err++; $display("FAIL burst_end_outstanding: got %0d want 0", dut.r_outstanding); end
    endtask

    task automatic test_single_port1();
        bus.req_request_i[DCACHE_PORT] = 1'b1;
        bus.req_lock_i[DCACHE_PORT]    = 1'b0;
        bus.req_address_i[DCACHE_PORT] = 32'h2000;
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b10) begin n_err++; $display("FAIL single_grant: got %b want 10", bus.req_grant_o); end
        n_cmp++; if (bus.mem_address_o !== 32'h2000) begin n_err++; $display("FAIL single_addr: got %h want 00002000", bus.mem_address_o); end
        cyc();
        n_cmp++; if (dut.r_state !== OWNED) begin n_err++; $display("FAIL single_owned: got %0d want %0d", dut.r_state, OWNED); end
        n_cmp++; if (dut.r_owner !== 1'b1) begin n_err++; $display("FAIL single_owner: got %0d want 1", dut.r_owner); end
        bus.req_request_i = '0;
        bus.mem_valid_i   = 1'b1;
        bus.mem_data_i    = 32'h0000_BEEF;
        #1;
        n_cmp++; if (bus.req_valid_o !== 2'b10) begin n_err++; $display("FAIL single_resp_valid: got %b want 10", bus.req_valid_o); end
        n_cmp++; if (bus.req_data_o !== 32'h0000_BEEF) begin n_err++; $display("FAIL single_resp_data: got %h want 0000beef", bus.req_data_o); end
        cyc();
        bus.mem_valid_i = 1'b0;
        n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL single_end_state: got %0d want %0d", dut.r_state, IDLE); end
        n_cmp++; if (dut.r_ptr !== 1'b0) begin n_err++; $display("FAIL single_end_ptr: got %0d want 0", dut.r_ptr); end
    endtask

    task automatic test_contention();
        bus.req_request_i = 2'b11;
        bus.req_lock_i    = 2'b01;
        bus.req_address_i[ICACHE_PORT] = 32'h3000;
        bus.req_address_i[DCACHE_PORT] = 32'h4000;
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b01) begin n_err++; $display("FAIL contend_first_grant: got %b want 01", bus.req_grant_o); end
        n_cmp++; if (bus.mem_address_o !== 32'h3000) begin n_err++; $display("FAIL contend_first_addr: got %h want 00003000", bus.mem_address_o); end
        cyc();
        bus.req_request_i[ICACHE_PORT] = 1'b0;
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b00) begin n_err++; $display("FAIL contend_stall_grant: got %b want 00", bus.req_grant_o); end
        cyc();
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = 32'h55;
        bus.req_lock_i[ICACHE_PORT] = 1'b0;
        #1;
        n_cmp++; if (bus.req_valid_o !== 2'b01) begin n_err++; $display("FAIL contend_resp0: got %b want 01", bus.req_valid_o); end
        n_cmp++; if (bus.req_grant_o !== 2'b00) begin n_err++; $display("FAIL contend_stall2_grant: got %b want 00", bus.req_grant_o); end
        cyc();
        bus.mem_valid_i = 1'b0;
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b10) begin n_err++; $display("FAIL contend_second_grant: got %b want 10", bus.req_grant_o); end
        n_cmp++; if (bus.mem_address_o !== 32'h4000) begin n_err++; $display("FAIL contend_second_addr: got %h want 00004000", bus.mem_address_o); end
        cyc();
        bus.req_request_i = '0;
        bus.mem_valid_i   = 1'b1;
        bus.mem_data_i    = 32'h66;
        #1;
        n_cmp++; if (bus.req_valid_o !== 2'b10) begin n_err++; $display("FAIL contend_resp1: got %b want 10", bus.req_valid_o); end
        cyc();
        bus.mem_valid_i = 1'b0;
        n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL contend_end_state: got %0d want %0d", dut.r_state, IDLE); end
        n_cmp++; if (dut.r_ptr !== 1'b0) begin n_err++; $display("FAIL contend_end_ptr: got %0d want 0", dut.r_ptr); end
    endtask

    task automatic test_full_stall();
        for (int k = 0; k < 8; k++) begin
            bus.req_request_i[ICACHE_PORT] = 1'b1;
            bus.req_lock_i[ICACHE_PORT]    = 1'b1;
            bus.req_address_i[ICACHE_PORT] = 32'h5000 + 32'(4 * k);
            #1;
            n_cmp++; if (bus.req_grant_o !== 2'b01) begin n_err++; $display("FAIL full_grant[%0d]: got %b want 01", k, bus.req_grant_o); end
            cyc();
        end
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b00) begin n_err++; $display("FAIL full_ninth_grant: got %b want 00", bus.req_grant_o); end
        n_cmp++; if (bus.mem_request_o !== 1'b0) begin n_err++; $display("FAIL full_ninth_mem_request: got %b want 0", bus.mem_request_o); end
        n_cmp++; if (dut.r_outstanding !== 4'd8) begin n_err++; $display("FAIL full_outstanding: got %0d want 8", dut.r_outstanding); end
        cyc();
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = 32'h77;
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b00) begin n_err++; $display("FAIL full_resp_cycle_grant: got %b want 00", bus.req_grant_o); end
        n_cmp++; if (bus.req_valid_o !== 2'b01) begin n_err++; $display("FAIL full_resp_valid: got %b want 01", bus.req_valid_o); end
        cyc();
        bus.mem_valid_i = 1'b0;
        #1;
        n_cmp++; if (bus.req_grant_o !== 2'b01) begin n_err++; $display("FAIL full_resume_grant: got %b want 01", bus.req_grant_o); end
        cyc();
        bus.req_request_i = '0;
        bus.req_lock_i    = '0;
        cyc();
        n_cmp++; if (dut.r_state !== DRAIN) begin n_err++; $display("FAIL full_drain_state: got %0d want %0d", dut.r_state, DRAIN); end
        n_cmp++; if (dut.r_outstanding !== 4'd8) begin n_err++; $display("FAIL full_drain_outstanding: got %0d want 8", dut.r_outstanding); end
        bus.mem_valid_i = 1'b1;
        repeat (8) cyc();
        bus.mem_valid_i = 1'b0;
        n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL full_end_state: got %0d want %0d", dut.r_state, IDLE); end
        n_cmp++; if (dut.r_ptr !== 1'b1) begin n_err++; $display("FAIL full_end_ptr: got %0d want 1", dut.r_ptr); end
    endtask

    task automatic test_invalidate();
        for (int k = 0; k < 3; k++) begin
            bus.req_request_i[ICACHE_PORT] = 1'b1;
            bus.req_lock_i[ICACHE_PORT]    = 1'b1;
            bus.req_address_i[ICACHE_PORT] = 32'h6000 + 32'(4 * k);
            #1;
            n_cmp++; if (bus.req_grant_o !== 2'b01) begin n_err++; $display("FAIL inval_grant[%0d]: got %b want 01", k, bus.req_grant_o); end
            cyc();
        end
        bus.req_request_i = '0;
        bus.mem_valid_i   = 1'b1;
        bus.mem_data_i    = 32'h88;
        #1;
        n_cmp++; if (bus.req_valid_o !== 2'b01) begin n_err++; $display("FAIL inval_first_resp: got %b want 01", bus.req_valid_o); end
        cyc();
        bus.mem_valid_i = 1'b0;
        bus.req_invalidate_i[DCACHE_PORT] = 1'b1;
        #1;
        n_cmp++; if (bus.mem_invalidate_o !== 1'b0) begin n_err++; $display("FAIL inval_non_owner: got %b want 0", bus.mem_invalidate_o); end
        cyc();
        bus.req_invalidate_i = '0;
        n_cmp++; if (dut.r_outstanding !== 4'd2) begin n_err++; $display("FAIL inval_non_owner_outstanding: got %0d want 2", dut.r_outstanding); end
        bus.req_invalidate_i[ICACHE_PORT] = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = 32'h99;
        #1;
        n_cmp++; if (bus.mem_invalidate_o !== 1'b1) begin n_err++; $display("FAIL inval_mem_invalidate: got %b want 1", bus.mem_invalidate_o); end
        n_cmp++; if (bus.req_valid_o !== 2'b00) begin n_err++; $display("FAIL inval_resp_dropped: got %b want 00", bus.req_valid_o); end
        cyc();
        bus.req_invalidate_i = '0;
        bus.mem_valid_i      = 1'b0;
        bus.req_lock_i       = '0;
        #1;
        n_cmp++; if (bus.mem_invalidate_o !== 1'b0) begin n_err++; $display("FAIL inval_one_cycle: got %b want 0", bus.mem_invalidate_o); end
        n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL inval_state: got %0d want %0d", dut.r_state, IDLE); end
        n_cmp++; if (dut.r_outstanding !== 4'd0) begin n_err++; $display("FAIL inval_outstanding: got %0d want 0", dut.r_outstanding); end
        n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL inval_perr: got %b want 0", perr); end
        bus.req_invalidate_i[ICACHE_PORT] = 1'b1;
        #1;
        n_cmp++; if (bus.mem_invalidate_o !== 1'b0) begin n_err++; $display("FAIL inval_idle_ignored: got %b want 0", bus.mem_invalidate_o); end
        cyc();
        bus.req_invalidate_i = '0;
    endtask

    task automatic test_protocol_error();
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = 32'hAA;
        #1;
        n_cmp++; if (bus.req_valid_o !== 2'b00) begin n_err++; $display("FAIL perr_no_route: got %b want 00", bus.req_valid_o); end
        cyc();
        bus.mem_valid_i = 1'b0;
        n_cmp++; if (perr !== 1'b1) begin n_err++; $display("FAIL perr_set: got %b want 1", perr); end
        repeat (3) cyc();
        n_cmp++; if (perr !== 1'b1) begin n_err++; $display("FAIL perr_sticky: got %b want 1", perr); end
        rst_n_i = 1'b0;
        #1;
        n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL perr_cleared_by_reset: got %b want 0", perr); end
        cyc();
        rst_n_i = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 2; k++) begin
            bus.req_request_i[DCACHE_PORT] = 1'b1;
            bus.req_lock_i[DCACHE_PORT]    = 1'b1;
            bus.req_address_i[DCACHE_PORT] = 32'h7000 + 32'(4 * k);
            cyc();
        end
        n_cmp++; if (dut.r_owner !== 1'b1) begin n_err++; $display("FAIL midrst_owner_before: got %0d want 1", dut.r_owner); end
        n_cmp++; if (dut.r_outstanding !== 4'd2) begin n_err++; $display("FAIL midrst_outstanding_before: got %0d want 2", dut.r_outstanding); end
        rst_n_i = 1'b0;
        clear_inputs();
        #1;
        n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want %0d", dut.r_state, IDLE); end
        n_cmp++; if (dut.r_outstanding !== 4'd0) begin n_err++; $display("FAIL midrst_outstanding: got %0d want 0", dut.r_outstanding); end
        n_cmp++; if (dut.r_owner !== 1'b0) begin n_err++; $display("FAIL midrst_owner: got %0d want 0", dut.r_owner); end
        cyc();
        rst_n_i = 1'b1;
        cyc();
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = 32'hBB;
        #1;
        n_cmp++; if (bus.req_valid_o !== 2'b00) begin n_err++; $display("FAIL midrst_late_resp_route: got %b want 00", bus.req_valid_o); end
        cyc();
        bus.mem_valid_i = 1'b0;
        n_cmp++; if (perr !== 1'b1) begin n_err++; $display("FAIL midrst_late_resp_perr: got %b want 1", perr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_burst();
        test_single_port1();
        test_contention();
        test_full_stall();
        test_invalidate();
        test_protocol_error();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
